branch_resolver: RTL

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/branch_resolver.sv
// ---------------------------------------------------------------------------
// branch_resolver
// Resolves a conditional branch in one cycle. It picks the condition flag,
// computes the next PC and flags a misprediction. The result is held in a
// one-entry output register with valid/ready handshakes. A mispredict
// produces a one-cycle fetch-redirect pulse that does not wait for the
// consumer.
//
// Parameters
//   PC_STEP         fall-through increment added to req_pc
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_*           request channel (valid/ready, flags, cond, pc, target,
//                   prediction)
//   resp_*          registered result channel (valid/ready, taken, next_pc,
//                   mispredict)
//   redirect_*      one-cycle redirect pulse and its target address
//   stats_clr, taken_cnt, nottaken_cnt, mispred_cnt
//                   saturating statistics, present only when BRANCH_STATS_EN
//                   is defined
// ---------------------------------------------------------------------------
module branch_resolver #(
   parameter logic [31:0] PC_STEP = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_flags,
   input  logic [2:0]  req_cond,
   input  logic [31:0] req_pc,
   input  logic [31:0] req_target,
   input  logic        req_pred_taken,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_taken,
   output logic [31:0] resp_next_pc,
   output logic        resp_mispredict,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
`ifdef BRANCH_STATS_EN
   ,
   input  logic        stats_clr,
   output logic [15:0] taken_cnt,
   output logic [15:0] nottaken_cnt,
   output logic [15:0] mispred_cnt
`endif
);

   typedef enum logic {EMPTY, FULL} state_e;

   state_e      state_q, state_d;
   logic        accept;
   logic        taken;
   logic        mispredict;
   logic [31:0] next_pc;

   logic        resp_taken_q;
   logic [31:0] resp_next_pc_q;
   logic        resp_mispredict_q;
   logic        redirect_valid_q;
   logic [31:0] redirect_pc_q;

   // Resolution datapath; the add wraps modulo 2^32.
   assign taken      = req_flags[req_cond];
   assign next_pc    = taken ? req_target : (req_pc + PC_STEP);
   assign mispredict = taken ^ req_pred_taken;

   // NOTE: every signal gets a default at the top of the block, so no path
   // through the case statement can leave it unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      resp_valid = (state_q == FULL);
      req_ready  = !resp_valid || resp_ready;
      accept     = req_valid && req_ready;
      case (state_q)
         EMPTY:   if (accept) state_d = FULL;
         FULL:    if (resp_ready && !accept) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments. All registers then
   // update together on the edge, whatever order the statements are in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // Result registers load only on acceptance. A stalled result cannot be
   // overwritten because req_ready is low while it waits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_taken_q      <= 1'b0;
         resp_next_pc_q    <= 32'd0;
         resp_mispredict_q <= 1'b0;
      end else if (accept) begin
         resp_taken_q      <= taken;
         resp_next_pc_q    <= next_pc;
         resp_mispredict_q <= mispredict;
      end
   end

   // The redirect pulse depends only on acceptance, never on resp_ready.
   // Back-to-back mispredicts keep it high on consecutive cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= 32'd0;
      end else begin
         redirect_valid_q <= accept && mispredict;
         if (accept && mispredict) redirect_pc_q <= next_pc;
      end
   end

   assign resp_taken      = resp_taken_q;
   assign resp_next_pc    = resp_next_pc_q;
   assign resp_mispredict = resp_mispredict_q;
   assign redirect_valid  = redirect_valid_q;
   assign redirect_pc     = redirect_pc_q;

`ifdef BRANCH_STATS_EN
   logic [15:0] taken_cnt_q, nottaken_cnt_q, mispred_cnt_q;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // The clear has priority over an increment in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken_cnt_q    <= 16'd0;
         nottaken_cnt_q <= 16'd0;
         mispred_cnt_q  <= 16'd0;
      end else if (stats_clr) begin
         taken_cnt_q    <= 16'd0;
         nottaken_cnt_q <= 16'd0;
         mispred_cnt_q  <= 16'd0;
      end else if (accept) begin
         if (taken) taken_cnt_q    <= sat_inc(taken_cnt_q);
         else       nottaken_cnt_q <= sat_inc(nottaken_cnt_q);
         if (mispredict) mispred_cnt_q <= sat_inc(mispred_cnt_q);
      end
   end

   assign taken_cnt    = taken_cnt_q;
   assign nottaken_cnt = nottaken_cnt_q;
   assign mispred_cnt  = mispred_cnt_q;
`endif

endmodule
